la_iocut_seq: RTL

- Parametrised, controllable successor to the passive IO-ring cut cell.
- Drives per-channel bridge switches between left and right ring segments (ioring0/ioring1), plus one bridge for the vddio supply.
- Every reconfiguration is break-before-make with a programmable dead time, under a valid/ready request handshake.
- Sits in the always-on digital control next to the physical cut cell in each side's padring.

---
 rtl/la_iocut_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/la_iocut_seq.sv
// la_iocut_seq -- sequenced, break-before-make controller for the IO-ring cut.
//
// It drives the bridge switches that join the left and right ring segments
// (ioring0[i] <-> ioring1[i]) and the vddio0/vddio1 supply bridge. Each
// reconfiguration runs in this order:
//   1. open every channel that must open (break),
//   2. wait a programmable dead time,
//   3. close the channels the new target wants closed (make).
// Channels that are closed in both the old and the new state are never opened.
//
// Optional feature, enabled by defining LA_IOCUT_SWACK_EN:
//   - adds input sw_ack (switch status feedback, 1 = closed);
//   - BREAK waits until every opened channel reports open;
//   - a VERIFY state waits until sw_ack matches sw_en;
//   - both waits time out after 2^DEADW-1 cycles. A timeout sets the sticky
//     err flag and cuts every bridge, then the sequence ends normally.
//   Without the macro, err is tied to 0.
//
// Parameters:
//   PROP, SIDE   cell type and ring side of the physical cut (no behavioural effect)
//   RINGW        number of ioring channels bridged
//   DEADW        width of the dead-time counter
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, never during reset)
//   req_mask, req_pwr     target channel bridges / target vddio bridge
//   dead_cycles           dead time in cycles, sampled at accept
//   sw_ack                switch feedback (LA_IOCUT_SWACK_EN only)
//   sw_en, pwr_en         bridge switch enables
//   busy                  high in BREAK/DEAD/MAKE (and VERIFY)
//   done                  one-cycle completion pulse
//   err                   sticky switch-feedback error
module la_iocut_seq #(
    parameter string PROP  = "DEFAULT",
    parameter string SIDE  = "NO",
    parameter int    RINGW = 8,
    parameter int    DEADW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [RINGW-1:0] req_mask,
    input  logic             req_pwr,
    input  logic [DEADW-1:0] dead_cycles,
`ifdef LA_IOCUT_SWACK_EN
    input  logic [RINGW-1:0] sw_ack,
`endif
    output logic [RINGW-1:0] sw_en,
    output logic             pwr_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // PROP and SIDE only describe the physical cut cell. They have no
    // behavioural effect here, so this block is intentionally empty.
    if (PROP == "" || SIDE == "") begin : g_unnamed_cut
    end

    typedef enum logic [2:0] {
        st_idle,
        st_break,
        st_dead,
        st_make,
`ifdef LA_IOCUT_SWACK_EN
        st_verify,
`endif
        st_done
    } state_t;

    state_t           state, state_n;
    logic [RINGW-1:0] sw_n, tgt, tgt_n;
    logic             pwr_n, tpwr, tpwr_n;
    // cnt holds the dead time from accept onward. DEAD is only entered with
    // cnt >= 1 and leaves at cnt == 1, so the counter never underflows.
    logic [DEADW-1:0] cnt, cnt_n;

`ifdef LA_IOCUT_SWACK_EN
    // The last count value before a timeout. Counting 0..tmo_last spans
    // 2^DEADW-1 waiting cycles.
    localparam logic [DEADW-1:0] tmo_last = {{(DEADW-1){1'b1}}, 1'b0};

    logic [DEADW-1:0] tcnt, tcnt_n;
    logic             err_q, err_n;
    logic             brk_pending;

    // A channel being opened still reports closed.
    assign brk_pending = |(sw_ack & ~tgt);
    assign err         = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready = (state == st_idle) && !reset;
    assign done      = (state == st_done);
    assign busy      = (state != st_idle) && (state != st_done);

    always_comb begin
        state_n = state;
        sw_n    = sw_en;
        pwr_n   = pwr_en;
        tgt_n   = tgt;
        tpwr_n  = tpwr;
        cnt_n   = cnt;
`ifdef LA_IOCUT_SWACK_EN
        tcnt_n  = tcnt;
        err_n   = err_q;
`endif
        case (state)
            st_idle: begin
                if (req_valid) begin
                    tgt_n  = req_mask;
                    tpwr_n = req_pwr;
                    cnt_n  = dead_cycles;
`ifdef LA_IOCUT_SWACK_EN
                    tcnt_n = '0;
`endif
                    // A request for the current state skips the sequence
                    // but still reports completion.
                    if (req_mask == sw_en && req_pwr == pwr_en)
                        state_n = st_done;
                    else
                        state_n = st_break;
                end
            end
            st_break: begin
                // Only clear bits; nothing closes here.
                sw_n  = sw_en & tgt;
                pwr_n = pwr_en & tpwr;
`ifdef LA_IOCUT_SWACK_EN
                if (brk_pending) begin
                    if (tcnt == tmo_last) begin
                        err_n   = 1'b1;
                        sw_n    = '0;
                        pwr_n   = 1'b0;
                        state_n = st_done;
                    end else begin
                        tcnt_n  = tcnt + 1'b1;
                    end
                end else begin
                    state_n = (cnt == '0) ? st_make : st_dead;
                end
`else
                state_n = (cnt == '0) ? st_make : st_dead;
`endif
            end
            st_dead: begin
                cnt_n = cnt - 1'b1;
                if (cnt == {{(DEADW-1){1'b0}}, 1'b1})
                    state_n = st_make;
            end
            st_make: begin
                sw_n  = tgt;
                pwr_n = tpwr;
`ifdef LA_IOCUT_SWACK_EN
                tcnt_n  = '0;
                state_n = st_verify;
`else
                state_n = st_done;
`endif
            end
`ifdef LA_IOCUT_SWACK_EN
            st_verify: begin
                if (sw_ack == sw_en) begin
                    state_n = st_done;
                end else if (tcnt == tmo_last) begin
                    err_n   = 1'b1;
                    sw_n    = '0;
                    pwr_n   = 1'b0;
                    state_n = st_done;
                end else begin
                    tcnt_n  = tcnt + 1'b1;
                end
            end
`endif
            st_done: state_n = st_idle;
            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= st_idle;
            sw_en  <= '0;
            pwr_en <= 1'b0;
            tgt    <= '0;
            tpwr   <= 1'b0;
            cnt    <= '0;
`ifdef LA_IOCUT_SWACK_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sw_en  <= sw_n;
            pwr_en <= pwr_n;
            tgt    <= tgt_n;
            tpwr   <= tpwr_n;
            cnt    <= cnt_n;
`ifdef LA_IOCUT_SWACK_EN
            tcnt   <= tcnt_n;
            err_q  <= err_n;
`endif
        end
    end

endmodule
